// File: rtl/f32_to_int_seq.sv
// f32_to_int_seq
// Sequential IEEE-754 single-precision to signed 32-bit integer converter.
// The result is truncated toward zero. The block consumes the float quotient from
// the upstream divider and returns a two's-complement word with status flags.
// A normal operand's mantissa moves one bit per cycle through a small FSM.
// Special operands (NaN, Inf, out of range, |x| < 1) are resolved on the accept edge.
//
// Parameters
//   SAT_EN      1: an overflow/Inf result saturates to 0x7FFFFFFF / 0x80000000
//               0: an overflow/Inf result gives out_int = 0 (out_ovf is still set)
// Ports
//   clk         clock; all state changes on the rising edge
//   rst         asynchronous reset, active-high
//   in_valid    in_f is valid
//   in_ready    block can accept in_f (IDLE and not in reset)
//   in_f        IEEE-754 single {sign, exp[7:0], frac[22:0]}
//   out_valid   out_int and flags are valid
//   out_ready   consumer takes the result
//   out_int     signed result, truncated toward zero
//   out_ovf     |value| >= 2^31 (except exactly -2^31), or +/-Inf
//   out_nan     input was NaN (out_int = 0)
//   out_inexact nonzero fraction bits were discarded
module f32_to_int_seq #(
    parameter bit SAT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_f,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_int,
    output logic        out_ovf,
    output logic        out_nan,
    output logic        out_inexact
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Value returned for an overflowing operand of the given sign.
    function automatic logic [31:0] ovf_value(input logic sign);
        logic [31:0] val;
        if (SAT_EN) begin
            val = sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            val = 32'h0000_0000;
        end
        return val;
    endfunction

    state_t      state_q, state_d;
    logic [31:0] mag_q, mag_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        left_q, left_d;
    logic        sticky_q, sticky_d;
    logic        sign_q, sign_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_int_q, out_int_d;
    logic        ovf_q, ovf_d;
    logic        nan_q, nan_d;
    logic        inexact_q, inexact_d;

    logic        in_sign_s;
    logic [7:0]  in_exp_s;
    logic [22:0] in_frac_s;
    logic [7:0]  left_cnt_s;
    logic [7:0]  right_cnt_s;

    assign in_sign_s   = in_f[31];
    assign in_exp_s    = in_f[30:23];
    assign in_frac_s   = in_f[22:0];
    // Biased exponent 150 is E = 23. Above it the mantissa moves left, below it right.
    assign left_cnt_s  = in_exp_s - 8'd150;
    assign right_cnt_s = 8'd150 - in_exp_s;

    // Next-state and next-output logic for the whole converter.
    always_comb begin
        state_d     = state_q;
        mag_d       = mag_q;
        cnt_d       = cnt_q;
        left_d      = left_q;
        sticky_d    = sticky_q;
        sign_d      = sign_q;
        out_valid_d = out_valid_q;
        out_int_d   = out_int_q;
        ovf_d       = ovf_q;
        nan_d       = nan_q;
        inexact_d   = inexact_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    ovf_d     = 1'b0;
                    nan_d     = 1'b0;
                    inexact_d = 1'b0;
                    if ((in_exp_s == 8'hFF) && (in_frac_s != 23'd0)) begin
                        out_int_d = 32'h0000_0000;
                        nan_d     = 1'b1;
                        state_d   = ST_DONE;
                    end else if (in_f == 32'hCF00_0000) begin
                        // Exactly -2^31 is representable; it is not an overflow.
                        out_int_d = 32'h8000_0000;
                        state_d   = ST_DONE;
                    end else if (in_exp_s >= 8'd158) begin
                        // Covers both Inf (exp 255) and E >= 31.
                        out_int_d = ovf_value(in_sign_s);
                        ovf_d     = 1'b1;
                        state_d   = ST_DONE;
                    end else if (in_exp_s < 8'd127) begin
                        // |x| < 1 truncates to zero. Denormals are flushed but still inexact.
                        out_int_d = 32'h0000_0000;
                        inexact_d = (in_f[30:0] != 31'd0);
                        state_d   = ST_DONE;
                    end else begin
                        mag_d    = {8'd0, 1'b1, in_frac_s};
                        sign_d   = in_sign_s;
                        sticky_d = 1'b0;
                        if (in_exp_s >= 8'd150) begin
                            left_d = 1'b1;
                            cnt_d  = left_cnt_s[4:0];
                        end else begin
                            left_d = 1'b0;
                            cnt_d  = right_cnt_s[4:0];
                        end
                        state_d = ST_SHIFT;
                    end
                    // Special cases raise out_valid one cycle after entering DONE.
                    out_valid_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_q != 5'd0) begin
                    if (left_q) begin
                        mag_d = {mag_q[30:0], 1'b0};
                    end else begin
                        mag_d    = {1'b0, mag_q[31:1]};
                        sticky_d = sticky_q | mag_q[0];
                    end
                    cnt_d = cnt_q - 5'd1;
                end else begin
                    out_int_d   = sign_q ? (32'd0 - mag_q) : mag_q;
                    ovf_d       = 1'b0;
                    nan_d       = 1'b0;
                    inexact_d   = sticky_q;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // Converter state and registered outputs. Reset aborts any conversion in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mag_q       <= 32'd0;
            cnt_q       <= 5'd0;
            left_q      <= 1'b0;
            sticky_q    <= 1'b0;
            sign_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_int_q   <= 32'd0;
            ovf_q       <= 1'b0;
            nan_q       <= 1'b0;
            inexact_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mag_q       <= mag_d;
            cnt_q       <= cnt_d;
            left_q      <= left_d;
            sticky_q    <= sticky_d;
            sign_q      <= sign_d;
            out_valid_q <= out_valid_d;
            out_int_q   <= out_int_d;
            ovf_q       <= ovf_d;
            nan_q       <= nan_d;
            inexact_q   <= inexact_d;
        end
    end

    assign in_ready    = (state_q == ST_IDLE) && !rst;
    assign out_valid   = out_valid_q;
    assign out_int     = out_int_q;
    assign out_ovf     = ovf_q;
    assign out_nan     = nan_q;
    assign out_inexact = inexact_q;

endmodule

// File: tb/tb_f32_to_int_seq.sv
// Directed bench for f32_to_int_seq. Two instances share all inputs:
// dut1 with SAT_EN=1 and dut0 with SAT_EN=0. Each result is packed as
// {out_int, out_ovf, out_nan, out_inexact}.
module tb_f32_to_int_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_f = 32'd0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, out_ovf, out_nan, out_inexact;
    logic [31:0] out_int;
    logic        in_ready0, out_valid0, out_ovf0, out_nan0, out_inexact0;
    logic [31:0] out_int0;

    int total_cnt = 0;
    int pass_cnt  = 0;

    typedef struct packed {
        logic [31:0] f;
        logic [31:0] i;
        logic [2:0]  fl;   // {ovf, nan, inexact}
        logic [7:0]  lat;
    } vec_t;

    f32_to_int_seq #(.SAT_EN(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_f(in_f),
        .out_valid(out_valid), .out_ready(out_ready), .out_int(out_int),
        .out_ovf(out_ovf), .out_nan(out_nan), .out_inexact(out_inexact)
    );

    f32_to_int_seq #(.SAT_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_f(in_f),
        .out_valid(out_valid0), .out_ready(out_ready), .out_int(out_int0),
        .out_ovf(out_ovf0), .out_nan(out_nan0), .out_inexact(out_inexact0)
    );

    always #5 clk = ~clk;

    // Feed one operand and wait (bounded) for the result. Latency is counted in
    // rising edges after the accept edge. Then complete the output handshake.
    task automatic do_convert(input logic [31:0] f, output logic [34:0] r1,
                              output logic [34:0] r0, output int lat, output logic [1:0] post);
        @(negedge clk);
        in_f = f;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_f = 32'hDEAD_BEEF;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        r1 = {out_int, out_ovf, out_nan, out_inexact};
        r0 = {out_int0, out_ovf0, out_nan0, out_inexact0};
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        post = {out_valid, in_ready};
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        total_cnt++;
        if ({in_ready, out_valid, out_int, out_ovf, out_nan, out_inexact} !== 37'd0) begin
            $display("FAIL reset_state: got in_rdy=%0b vld=%0b int=%h flags=%b, want all 0",
                     in_ready, out_valid, out_int, {out_ovf, out_nan, out_inexact});
        end else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1) begin
            $display("FAIL reset_release_ready: got %0b want 1", in_ready);
        end else pass_cnt++;
    endtask

    task automatic test_normal();
        vec_t v[7] = '{
            '{32'h4188_0000, 32'd17,          3'b000, 8'd20},  // 17.0
            '{32'hC048_0000, 32'hFFFF_FFFD,   3'b001, 8'd23},  // -3.125
            '{32'h3F80_0000, 32'd1,           3'b000, 8'd24},  // 1.0
            '{32'h4E6E_6B28, 32'h3B9A_CA00,   3'b000, 8'd7},   // 1e9
            '{32'h4B00_0000, 32'h0080_0000,   3'b000, 8'd1},   // 2^23, no shift
            '{32'h4EFF_FFFF, 32'h7FFF_FF80,   3'b000, 8'd8},   // largest below 2^31
            '{32'hC18C_0000, 32'hFFFF_FFEF,   3'b001, 8'd20}   // -17.5
        };
        logic [34:0] r1, r0;
        logic [1:0]  post;
        int          lat;
        for (int k = 0; k < 7; k++) begin
            do_convert(v[k].f, r1, r0, lat, post);
            total_cnt++;
            if (r1 !== {v[k].i, v[k].fl}) begin
                $display("FAIL normal_sat1 %h: got %h/%b want %h/%b", v[k].f, r1[34:3], r1[2:0], v[k].i, v[k].fl);
            end else pass_cnt++;
            total_cnt++;
            if (r0 !== {v[k].i, v[k].fl}) begin
                $display("FAIL normal_sat0 %h: got %h/%b want %h/%b", v[k].f, r0[34:3], r0[2:0], v[k].i, v[k].fl);
            end else pass_cnt++;
            total_cnt++;
            if (lat !== int'(v[k].lat)) begin
                $display("FAIL normal_latency %h: got %0d want %0d", v[k].f, lat, v[k].lat);
            end else pass_cnt++;
            total_cnt++;
            if (post !== 2'b01) begin
                $display("FAIL normal_handshake %h: got vld,rdy=%b want 01", v[k].f, post);
            end else pass_cnt++;
        end
    endtask

    task automatic test_special();
        vec_t v[8] = '{
            '{32'h3EB8_51EC, 32'h0000_0000, 3'b001, 8'd1},  // 0.36
            '{32'h0000_0000, 32'h0000_0000, 3'b000, 8'd1},  // +0
            '{32'h8000_0001, 32'h0000_0000, 3'b001, 8'd1},  // negative denormal
            '{32'h4F00_0000, 32'h7FFF_FFFF, 3'b100, 8'd1},  // 2^31
            '{32'hCF00_0000, 32'h8000_0000, 3'b000, 8'd1},  // exactly -2^31
            '{32'hCF00_0001, 32'h8000_0000, 3'b100, 8'd1},  // just beyond -2^31
            '{32'hFF80_0000, 32'h8000_0000, 3'b100, 8'd1},  // -Inf
            '{32'h7FC0_0000, 32'h0000_0000, 3'b010, 8'd1}   // NaN
        };
        logic [34:0] r1, r0;
        logic [31:0] exp0;
        logic [1:0]  post;
        int          lat;
        for (int k = 0; k < 8; k++) begin
            do_convert(v[k].f, r1, r0, lat, post);
            exp0 = v[k].fl[2] ? 32'd0 : v[k].i;
            total_cnt++;
            if (r1 !== {v[k].i, v[k].fl}) begin
                $display("FAIL special_sat1 %h: got %h/%b want %h/%b", v[k].f, r1[34:3], r1[2:0], v[k].i, v[k].fl);
            end else pass_cnt++;
            total_cnt++;
            if (r0 !== {exp0, v[k].fl}) begin
                $display("FAIL special_sat0 %h: got %h/%b want %h/%b", v[k].f, r0[34:3], r0[2:0], exp0, v[k].fl);
            end else pass_cnt++;
            total_cnt++;
            if (lat !== int'(v[k].lat)) begin
                $display("FAIL special_latency %h: got %0d want %0d", v[k].f, lat, v[k].lat);
            end else pass_cnt++;
            total_cnt++;
            if (post !== 2'b01) begin
                $display("FAIL special_handshake %h: got vld,rdy=%b want 01", v[k].f, post);
            end else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        int lat = 0;
        int bad = 0;
        @(negedge clk);
        in_f = 32'h4188_0000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_f = 32'h3F80_0000;  // still offered, must be ignored
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_f = in_f + 32'd1;
            if (!(out_valid === 1'b1 && in_ready === 1'b0 && out_int === 32'd17 &&
                  {out_ovf, out_nan, out_inexact} === 3'b000)) bad++;
        end
        total_cnt++;
        if (bad != 0) begin
            $display("FAIL backpressure_hold: got %0d unstable cycles (lat=%0d) want 0", bad, lat);
        end else pass_cnt++;
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total_cnt++;
        if ({out_valid, in_ready, out_int} !== {2'b01, 32'd17}) begin
            $display("FAIL backpressure_release: got vld=%0b rdy=%0b int=%h want 0 1 00000011",
                     out_valid, in_ready, out_int);
        end else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [34:0] r1, r0;
        logic [1:0]  post;
        int          lat;
        @(negedge clk);
        in_f = 32'h3F80_0000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        total_cnt++;
        if ({out_valid, out_int, in_ready} !== 34'd0) begin
            $display("FAIL reset_mid_shift: got vld=%0b int=%h rdy=%0b want 0 0 0", out_valid, out_int, in_ready);
        end else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        do_convert(32'h4E6E_6B28, r1, r0, lat, post);
        total_cnt++;
        if ({r1, lat} !== {32'h3B9A_CA00, 3'b000, 32'd7}) begin
            $display("FAIL reset_then_convert: got %h/%b lat=%0d want 3b9aca00/000 lat=7", r1[34:3], r1[2:0], lat);
        end else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_normal();
        test_special();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
